// File: rtl/ccd_reader_pkg.sv
// Shared types and defaults for the linear-CCD dark-run reader.
// Build option: CCD_READER_MIN_WIDTH_EN enables rejection of short dark runs.
package ccd_reader_pkg;

  localparam int DEF_PIX_W      = 11;
  localparam int DEF_NUM_PIXELS = 1536;
  localparam int DEF_MIN_WIDTH  = 4;

  // Reported when a line contains no dark pixel at all.
  localparam logic [DEF_PIX_W-1:0] NO_EDGE = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    state_t                 state;
    logic [DEF_PIX_W-1:0]   pix_cnt;
    logic                   found;
    logic                   closed;
  } ccd_dbg_t;

endpackage

// File: rtl/ccd_reader_if.sv
// Signal bundle between the CCD timing generator (master) and the reader (slave).
interface ccd_reader_if
  import ccd_reader_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);
  // Strobes are level pulses with no ready/backpressure; data_out_valid is a
  // one-clock qualifier and data_out is only meaningful on that cycle.
  logic             data_in;
  logic             en_pulse;
  logic             sh_pulse;
  logic             ccd_pulse;
  logic [PIX_W-1:0] data_out;
  logic             data_out_valid;

  modport master (
    output data_in, en_pulse, sh_pulse, ccd_pulse,
    input  data_out, data_out_valid
  );

  modport slave (
    input  data_in, en_pulse, sh_pulse, ccd_pulse,
    output data_out, data_out_valid
  );

endinterface

// File: rtl/ccd_sync_edge.sv
// Two-flop synchronizer with an optional registered rising-edge detector.
module ccd_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
    end else begin
      meta_q <= {meta_q[0], async_i};
    end
  end

  assign sync_o = meta_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic dly_q;
      logic rise_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_q  <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          dly_q  <= meta_q[1];
          rise_q <= meta_q[1] & ~dly_q;
        end
      end

      assign rise_o = rise_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ccd_reader.sv
// Finds the first dark run of each CCD line and reports its centre pixel.
// Build option: CCD_READER_MIN_WIDTH_EN discards runs shorter than MIN_WIDTH.
module ccd_reader
  import ccd_reader_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS
`ifdef CCD_READER_MIN_WIDTH_EN
  , parameter int MIN_WIDTH = DEF_MIN_WIDTH
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  ccd_reader_if.slave  bus,
  output ccd_dbg_t     dbg_o
);

  localparam logic [PIX_W-1:0] CNT_MAX = PIX_W'(NUM_PIXELS);
  localparam logic [PIX_W-1:0] ONE     = PIX_W'(1);
`ifdef CCD_READER_MIN_WIDTH_EN
  localparam logic [PIX_W-1:0] MIN_W   = PIX_W'(MIN_WIDTH);
`endif

  logic data_s;
  logic sh_rise;
  logic ccd_rise;
  logic data_rise_unused;
  logic sh_sync_unused;
  logic ccd_sync_unused;

  ccd_sync_edge #(.EDGE_EN(1'b0)) u_sync_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.data_in),
    .sync_o  (data_s),
    .rise_o  (data_rise_unused)
  );

  ccd_sync_edge #(.EDGE_EN(1'b1)) u_sync_sh (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.sh_pulse),
    .sync_o  (sh_sync_unused),
    .rise_o  (sh_rise)
  );

  ccd_sync_edge #(.EDGE_EN(1'b1)) u_sync_ccd (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.ccd_pulse),
    .sync_o  (ccd_sync_unused),
    .rise_o  (ccd_rise)
  );

  state_t           state_q;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [PIX_W-1:0] start_q;
  logic [PIX_W-1:0] stop_q;
  logic [PIX_W-1:0] data_out_q;
  logic             found_q;
  logic             closed_q;
  logic             valid_q;

  logic [PIX_W-1:0] stop_d;
  logic [PIX_W:0]   sum_d;
  logic [PIX_W-1:0] center_d;

  // An unclosed run ends at the last pixel actually sampled in this line.
  always_comb begin
    stop_d   = closed_q ? stop_q : (pix_cnt_q - ONE);
    sum_d    = {1'b0, start_q} + {1'b0, stop_d};
    center_d = found_q ? sum_d[PIX_W:1] : {PIX_W{1'b1}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      data_out_q <= '0;
      found_q    <= 1'b0;
      closed_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.en_pulse) begin
        state_q   <= IDLE;
        pix_cnt_q <= '0;
        found_q   <= 1'b0;
        closed_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sh_rise) begin
              state_q   <= SCAN;
              pix_cnt_q <= '0;
              found_q   <= 1'b0;
              closed_q  <= 1'b0;
            end
          end
          SCAN: begin
            // sh_rise takes priority, so a coincident pixel strobe is lost.
            if (sh_rise) begin
              data_out_q <= center_d;
              valid_q    <= 1'b1;
              pix_cnt_q  <= '0;
              found_q    <= 1'b0;
              closed_q   <= 1'b0;
            end else if (ccd_rise && (pix_cnt_q < CNT_MAX)) begin
              if (!found_q && !data_s) begin
                start_q <= pix_cnt_q;
                found_q <= 1'b1;
              end
              if (found_q && !closed_q && data_s) begin
`ifdef CCD_READER_MIN_WIDTH_EN
                if ((pix_cnt_q - start_q) < MIN_W) begin
                  found_q <= 1'b0;
                end else begin
                  stop_q   <= pix_cnt_q - ONE;
                  closed_q <= 1'b1;
                end
`else
                stop_q   <= pix_cnt_q - ONE;
                closed_q <= 1'b1;
`endif
              end
              pix_cnt_q <= pix_cnt_q + ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_q;

  always_comb begin
    dbg_o         = '0;
    dbg_o.state   = state_q;
    dbg_o.pix_cnt = DEF_PIX_W'(pix_cnt_q);
    dbg_o.found   = found_q;
    dbg_o.closed  = closed_q;
  end

endmodule

// File: tb/tb_ccd_reader.sv
// Self-checking bench for ccd_reader: directed lines plus random dark-run lines
// checked against a per-line sample model.
module tb_ccd_reader;
  import ccd_reader_pkg::*;

  localparam int PW = DEF_PIX_W;
  localparam int NP = DEF_NUM_PIXELS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #2 clk = ~clk;

  ccd_reader_if #(.PIX_W(PW)) bus();
  ccd_dbg_t dbg;

  ccd_reader #(.PIX_W(PW), .NUM_PIXELS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg_o (dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [PW-1:0] exp_q[$];
  bit            line_q[$];
  bit            active;
  logic [PW-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Centre of the first qualifying dark run among the samples of this line.
  function automatic logic [PW-1:0] line_result();
    int n;
    int i;
    int s;
    int e;
    n = line_q.size();
    i = 0;
    while (i < n) begin
      if (line_q[i] == 1'b0) begin
        s = i;
        while (i < n && line_q[i] == 1'b0) i++;
        e = i - 1;
`ifdef CCD_READER_MIN_WIDTH_EN
        if (i < n && (e - s + 1) < DEF_MIN_WIDTH) continue;
`endif
        return PW'((s + e) / 2);
      end
      i++;
    end
    return NO_EDGE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input bit d);
    @(negedge clk);
    bus.data_in = d;
    repeat (2) @(negedge clk);
    bus.ccd_pulse = 1'b1;
    @(negedge clk);
    bus.ccd_pulse = 1'b0;
    repeat (3) @(negedge clk);
    if (active && line_q.size() < NP) line_q.push_back(d);
  endtask

  task automatic check_cnt(input string tag);
    repeat (3) @(negedge clk);
    check(tag, 32'(dbg.pix_cnt), 32'(line_q.size()));
  endtask

  task automatic do_sh(input bit with_ccd);
    bit            exp_v;
    int            nvld;
    int            lat;
    logic [PW-1:0] got;
    logic [PW-1:0] exp_d;
    nvld  = 0;
    lat   = 0;
    got   = '0;
    exp_v = active;
    if (active) exp_q.push_back(line_result());
    line_q.delete();
    active = 1'b1;
    @(negedge clk);
    bus.sh_pulse = 1'b1;
    if (with_ccd) bus.ccd_pulse = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.ccd_pulse = 1'b0;
      if (k == 2) bus.sh_pulse = 1'b0;
      if (bus.data_out_valid) begin
        nvld++;
        if (lat == 0) begin
          lat = k;
          got = bus.data_out;
        end
      end
    end
    check("valid_cnt", 32'(nvld), exp_v ? 32'd1 : 32'd0);
    if (exp_v) begin
      exp_d = exp_q.pop_front();
      check("valid_lat", 32'(lat), 32'd4);
      check("data_out", 32'(got), 32'(exp_d));
      last_out = exp_d;
    end else begin
      check("data_hold", 32'(bus.data_out), 32'(last_out));
    end
    check("state_scan", 32'(dbg.state), 32'(SCAN));
  endtask

  task automatic drop_en();
    int nvld;
    nvld = 0;
    @(negedge clk);
    bus.en_pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_out_valid) nvld++;
    end
    check("en_state", 32'(dbg.state), 32'(IDLE));
    check("en_cnt", 32'(dbg.pix_cnt), 32'd0);
    check("en_novalid", 32'(nvld), 32'd0);
    bus.en_pulse = 1'b1;
    active = 1'b0;
    line_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int n_pix;
  int s1;
  int l1;
  int s2;
  int l2;
  int nvld0;
  bit all_lit;
  bit d;
  bit tail_pat[5];

  initial begin
    bus.data_in   = 1'b1;
    bus.en_pulse  = 1'b0;
    bus.sh_pulse  = 1'b0;
    bus.ccd_pulse = 1'b0;
    rst_n    = 1'b0;
    active   = 1'b0;
    last_out = '0;
    tail_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // 1: reset values, then enabled with no line start
    repeat (5) @(negedge clk);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.data_out_valid), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    check("rst_cnt", 32'(dbg.pix_cnt), 32'd0);
    rst_n = 1'b1;
    bus.en_pulse = 1'b1;
    nvld0 = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_out_valid) nvld0++;
    end
    for (int k = 0; k < 3; k++) send_pixel(1'b0);
    check_cnt("idle_cnt");
    check("idle_novalid", 32'(nvld0), 32'd0);
    check("idle_data", 32'(bus.data_out), 32'd0);

    // 2: first sh from IDLE is silent, dark run 100..172
    do_sh(1'b0);
    for (int p = 0; p < 200; p++) send_pixel(!(p >= 100 && p <= 172));
    check_cnt("l2_cnt");
    do_sh(1'b0);

    // 3: fully lit line, longer than NUM_PIXELS (counter saturates)
    for (int p = 0; p < NP + 4; p++) send_pixel(1'b1);
    check_cnt("l3_sat_cnt");
    do_sh(1'b0);

    // 4: dark from 1400 to end of line
    for (int p = 0; p < NP + 4; p++) send_pixel(!(p >= 1400));
    check_cnt("l4_sat_cnt");
    do_sh(1'b0);

    // 5: enable dropped mid-line
    for (int p = 0; p < 60; p++) send_pixel(!(p >= 20 && p <= 25));
    drop_en();
    do_sh(1'b0);
    for (int p = 0; p < 80; p++) send_pixel(!(p >= 40 && p <= 49));
    do_sh(1'b0);

    // 6: short run at 50 then run 300..309; line closed by sh coincident with a strobe
    for (int p = 0; p < 320; p++) send_pixel(!((p >= 50 && p <= 51) || (p >= 300 && p <= 309)));
    do_sh(1'b1);
    check_cnt("drop_cnt");
    for (int p = 0; p < 5; p++) send_pixel(tail_pat[p]);
    check_cnt("after_drop_cnt");
    do_sh(1'b0);

    // 7: random lines with up to two dark runs
    for (int r = 0; r < 8; r++) begin
      n_pix   = $urandom_range(30, 260);
      s1      = $urandom_range(0, n_pix);
      l1      = $urandom_range(1, 6);
      s2      = $urandom_range(0, n_pix);
      l2      = $urandom_range(1, 12);
      all_lit = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < n_pix; p++) begin
        d = 1'b1;
        if (!all_lit && ((p >= s1 && p < s1 + l1) || (p >= s2 && p < s2 + l2))) d = 1'b0;
        send_pixel(d);
      end
      check_cnt("rnd_cnt");
      do_sh(1'b0);
    end

    // ---------------- report ----------------
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
